// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
interface instr_fetch_unit_if #(parameter int XLEN = 32);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [31:0]     imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage of the multicycle core: owns PC and IR, runs the imem handshake
// on IMemRead and buffers the returned word until controlUnit asserts IrWrite.
module instr_fetch_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013,
  parameter int              CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             IMemRead,
  input  logic             IrWrite,
  input  logic             PcWrite,
  input  logic             PCSrc,
  input  logic [XLEN-1:0]  branch_target,
  instr_fetch_unit_if.master imem,
  output logic [XLEN-1:0]  pc,
  output logic [31:0]      ir,
  output logic [6:0]       opcode,
  output logic             fetch_busy,
  output logic             fetch_valid,
  output logic             fetch_err,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  state_t          state;
  logic [XLEN-1:0] fetchAddr;
  logic [31:0]     fetchBuf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      ir          <= NOP_INSTR;
      fetchAddr   <= '0;
      fetchBuf    <= '0;
      fetch_count <= '0;
      fetch_err   <= 1'b0;
    end else begin
      // PC update is independent of the fetch handshake; a mid-fetch change
      // does not disturb the latched fetchAddr.
      if (PcWrite)
        pc <= PCSrc ? branch_target : pc + XLEN'(4);
      case (state)
        IDLE: begin
          if (IMemRead) begin
            if (pc[1:0] == 2'b00) begin
              fetchAddr <= pc;
              state     <= REQ;
            end else begin
              fetch_err <= 1'b1;
            end
          end
        end
        REQ: begin
          if (imem.imem_ready) begin
            fetch_count <= fetch_count + CNT_W'(1);
            if (IrWrite) begin
              ir    <= imem.imem_rdata;
              state <= IDLE;
            end else begin
              fetchBuf <= imem.imem_rdata;
              state    <= DONE;
            end
          end
        end
        DONE: begin
          if (IrWrite) begin
            ir    <= fetchBuf;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Decoded straight from the state register so reset drops imem_req at once.
  assign imem.imem_req  = (state == REQ);
  assign imem.imem_addr = fetchAddr;
  assign fetch_busy     = (state == REQ);
  assign fetch_valid    = (state == DONE);
  assign opcode         = ir[6:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized and directed bench for instr_fetch_unit against a behavioural model.
module tb_instr_fetch_unit;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          IMemRead, IrWrite, PcWrite, PCSrc;
  logic [31:0]   branch_target;
  logic [31:0]   pc, ir;
  logic [6:0]    opcode;
  logic          fetch_busy, fetch_valid, fetch_err;
  logic [CW-1:0] fetch_count;

  instr_fetch_unit_if #(.XLEN(32)) imem ();

  instr_fetch_unit #(.XLEN(32), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .IMemRead(IMemRead), .IrWrite(IrWrite),
    .PcWrite(PcWrite), .PCSrc(PCSrc), .branch_target(branch_target),
    .imem(imem), .pc(pc), .ir(ir), .opcode(opcode), .fetch_busy(fetch_busy),
    .fetch_valid(fetch_valid), .fetch_err(fetch_err), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;

  // Model: a fetch is either outstanding, held in a buffer, or absent.
  logic [31:0] mPc, mIr, mAddr, mBuf;
  bit          mBusy, mHeld, mErr;
  int unsigned mFetches;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mPc = 32'h0; mIr = 32'h13; mAddr = 32'h0; mBuf = 32'h0;
    mBusy = 0; mHeld = 0; mErr = 0; mFetches = 0;
  endtask

  task automatic checkAll();
    chk("pc", pc, mPc);
    chk("ir", ir, mIr);
    chk("opcode", {25'b0, opcode}, {25'b0, mIr[6:0]});
    chk("imem_req", {31'b0, imem.imem_req}, {31'b0, mBusy});
    if (mBusy) chk("imem_addr", imem.imem_addr, mAddr);
    chk("fetch_busy", {31'b0, fetch_busy}, {31'b0, mBusy});
    chk("fetch_valid", {31'b0, fetch_valid}, {31'b0, mHeld});
    chk("fetch_err", {31'b0, fetch_err}, {31'b0, mErr});
    chk("fetch_count", {{(32-CW){1'b0}}, fetch_count}, mFetches % (1 << CW));
  endtask

  task automatic step(input bit imr, input bit iw, input bit pw, input bit ps,
                      input logic [31:0] bt, input bit rdy, input logic [31:0] rd);
    logic [31:0] pcNext;
    IMemRead = imr; IrWrite = iw; PcWrite = pw; PCSrc = ps; branch_target = bt;
    imem.imem_ready = rdy; imem.imem_rdata = rd;
    pcNext = pw ? (ps ? bt : mPc + 32'd4) : mPc;
    if (mBusy) begin
      if (rdy) begin
        mFetches++;
        mBusy = 0;
        if (iw) mIr = rd;
        else begin mBuf = rd; mHeld = 1; end
      end
    end else if (mHeld) begin
      if (iw) begin mIr = mBuf; mHeld = 0; end
    end else if (imr) begin
      if (mPc % 4 != 0) mErr = 1;
      else begin mBusy = 1; mAddr = mPc; end
    end
    mPc = pcNext;
    @(posedge clk);
    @(negedge clk);
    checkAll();
  endtask

  initial begin
    reset = 1'b0;
    IMemRead = 0; IrWrite = 0; PcWrite = 0; PCSrc = 0; branch_target = '0;
    imem.imem_ready = 0; imem.imem_rdata = '0;
    modelReset();
    repeat (2) @(negedge clk);
    checkAll();
    reset = 1'b1;
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);

    // Bypass fetch: three wait cycles, then ready with IrWrite.
    step(1, 0, 0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, $urandom);
    step(0, 1, 0, 0, 0, 1, 32'h0050_0093);
    chk("bypass_ir", ir, 32'h0050_0093);
    chk("bypass_cnt", {24'b0, fetch_count}, 32'd1);

    // Buffered fetch; IMemRead while DONE must be ignored.
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'h00A0_0113);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    chk("done_ir", ir, 32'h00A0_0113);

    // Branch during REQ leaves the address latched.
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 32'h40, 0, 0);
    chk("addr_held", imem.imem_addr, 32'h0);
    step(0, 1, 0, 0, 0, 1, $urandom);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("addr_branch", imem.imem_addr, 32'h40);
    step(0, 1, 0, 0, 0, 1, $urandom);

    // PC wrap at the top of the address space.
    step(0, 0, 1, 1, 32'hFFFF_FFFC, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    chk("pc_wrap", pc, 32'h0);

    // Drive the counter round to zero.
    while (mFetches % (1 << CW) != 0) begin
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 1, $urandom);
    end
    chk("count_wrap", {24'b0, fetch_count}, 32'd0);

    // Random traffic with aligned branch targets.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 1), $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 1), 32'($urandom_range(0, 255)) << 2,
           $urandom_range(0, 2) == 0, $urandom);

    // Drain any fetch in progress, then check misaligned fetch handling.
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 1, $urandom);
    step(0, 0, 1, 1, 32'h42, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("misalign_err", {31'b0, fetch_err}, 32'd1);
    chk("misalign_noreq", {31'b0, imem.imem_req}, 32'd0);
    step(0, 0, 1, 1, 32'h80, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, $urandom);
    chk("err_sticky", {31'b0, fetch_err}, 32'd1);

    // Reset asserted mid-REQ.
    step(1, 0, 0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    chk("rst_req", {31'b0, imem.imem_req}, 32'd0);
    chk("rst_ir", ir, 32'h13);
    modelReset();
    imem.imem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkAll();
    reset = 1'b1;
    step(0, 1, 0, 0, 0, 1, $urandom);
    step(0, 1, 0, 0, 0, 1, $urandom);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage of the multicycle RISC-V core. Sits directly upstream of controlUnit.
- Owns the PC and the instruction register (IR).
- Runs a req/ready handshake with instruction memory when controlUnit asserts IMemRead.
- Captures the fetched word on IrWrite and presents the opcode back to controlUnit.
- Advances the PC on PcWrite, selecting sequential or branch target via PCSrc.

Parameters:
- XLEN, 32, PC/address width.
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INSTR, 32'h0000_0013, IR value after reset (addi x0,x0,0).
- CNT_W, 16, width of the completed-fetch counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
- IMemRead  in  1  controlUnit: start a fetch at the current PC.
- IrWrite  in  1  controlUnit: load the fetched word into IR.
- PcWrite  in  1  controlUnit: update PC this cycle.
- PCSrc  in  1  controlUnit: 0 = PC+4, 1 = branch_target.
- branch_target  in  XLEN  target address from the ALU/AOut path.
- imem_req  out  1  memory request, held until imem_ready.
- imem_addr  out  XLEN  fetch address, stable while imem_req=1.
- imem_ready  in  1  memory accepts and returns data this cycle.
- imem_rdata  in  32  instruction word, valid when imem_ready=1.
- pc  out  XLEN  current PC.
- ir  out  32  instruction register.
- opcode  out  7  ir[6:0], to controlUnit decode.
- fetch_busy  out  1  1 while in REQ; controlUnit stalls on this.
- fetch_valid  out  1  1 in DONE: a word is buffered for IrWrite.
- fetch_err  out  1  sticky misaligned-fetch flag.
- fetch_count  out  CNT_W  completed fetches; wraps modulo 2^CNT_W.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, pc=RESET_PC, ir=NOP_INSTR.
  - fetch_addr=0, fetch_buf=0, fetch_count=0, fetch_err=0.
  - All outputs reflect these values immediately.
  - Reset mid-REQ drops imem_req combinationally; any later imem_ready is ignored.
- State machine, 2-bit encoding: IDLE, REQ, DONE.
- IDLE:
  - IMemRead=1 and pc[1:0]==0: fetch_addr<=pc, go to REQ.
  - IMemRead=1 and pc[1:0]!=0: fetch_err<=1, stay in IDLE, no request issued.
  - IrWrite in IDLE: ignored, ir unchanged.
- REQ:
  - imem_req=1 and imem_addr=fetch_addr (registered, so a PC change mid-fetch does not alter the address).
  - On imem_ready: fetch_count<=fetch_count+1.
  - If IrWrite=1 in the same cycle: ir<=imem_rdata (bypass), go to IDLE.
  - Otherwise: fetch_buf<=imem_rdata, go to DONE.
  - Without imem_ready: stay in REQ for any number of cycles.
  - IMemRead in REQ: ignored.
- DONE:
  - fetch_valid=1.
  - On IrWrite: ir<=fetch_buf, go to IDLE.
  - IMemRead without IrWrite: ignored; the buffered word is kept.
- PC update, independent of state:
  - If PcWrite=1: pc<=PCSrc ? branch_target : pc+4, truncated to XLEN (0xFFFF_FFFC+4 wraps to 0).
  - branch_target is loaded unmodified; misalignment is detected only at the next fetch.
- Sticky error: fetch_err clears only on reset.
- Derived outputs:
  - fetch_busy = (state==REQ).
  - fetch_valid = (state==DONE).
  - opcode = ir[6:0], combinational from ir.
- Latency: minimum IMemRead to ir update is 2 edges (IDLE→REQ, then REQ with imem_ready and IrWrite).

Test Plan:
- Reset release, then idle 3 cycles → pc=0, ir=0x00000013, opcode=0x13, imem_req=0, fetch_count=0.
- IMemRead at pc=0, memory ready after 3 wait cycles with rdata=0x00500093, IrWrite in that ready cycle → imem_req high for 4 cycles with addr=0, ir=0x00500093 (bypass), fetch_count=1, never enters DONE.
- Fetch with immediate ready and IrWrite 2 cycles later → DONE for 2 cycles with fetch_valid=1, then ir updated and state IDLE.
- PcWrite with PCSrc=1 and branch_target=0x40 during REQ → imem_addr stays 0x0 until ready, pc=0x40 afterwards, next fetch addr=0x40.
- PcWrite with PCSrc=1 and target=0x42, then IMemRead → fetch_err=1, imem_req never asserts, state IDLE; flag still 1 after a later aligned fetch.
- pc=0xFFFFFFFC with PcWrite and PCSrc=0 → pc=0x0; 65536 completed fetches → fetch_count wraps to 0; reset asserted mid-REQ → imem_req=0 immediately, ir=NOP.
